queue_out_mlane: RTL
====================

Name: queue_out_mlane

Overview:
- Parametrised successor to the BFS dual-lane output queue. Element-granular circular FIFO with ENQ_LANES enqueue lanes and DEQ_LANES dequeue lanes per cycle.
- Enqueued elements are compacted in lane order: no row structure and no half-filled rows.
- Sits between the BFS core's neighbour-emit stage and the memory-request/frontier writer. Reports occupancy, saturation and all-or-nothing batch acceptance.

Parameters:
- DATA_W, 32, width of one element (vertex address)
- ENQ_LANES, 2, maximum elements enqueued per cycle (>=1)
- DEQ_LANES, 2, maximum elements dequeued per cycle (>=1, <=Q_DEPTH)
- Q_DEPTH, 64, entries; power of two, >= max(ENQ_LANES,DEQ_LANES)
- SAT_THRESH, 8, queue_sat asserts when count >= SAT_THRESH

Ports:
- clk  in  1  clock
- bfs_rst_n  in  1  asynchronous active-low reset
- enqueue_req  in  ENQ_LANES  per-lane valid mask; any bit pattern allowed
- wdata_in  in  ENQ_LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- enq_accept  out  1  batch accepted this cycle (combinational)
- deq_num  in  $clog2(DEQ_LANES+1)  elements requested to pop this cycle
- rdata_out  out  DEQ_LANES*DATA_W  lane i = entry head+i
- rdata_valid  out  DEQ_LANES  bit i set iff count > i; thermometer-coded
- count  out  $clog2(Q_DEPTH)+1  occupancy
- queue_sat  out  1  count >= SAT_THRESH
- queue_full  out  1  free < ENQ_LANES
- queue_empty  out  1  count == 0

Behaviour:
- State:
  - mem[Q_DEPTH] of DATA_W.
  - head and tail, each $clog2(Q_DEPTH)+1 bits; the MSB is the wrap/polarity bit.
  - count = tail - head (modular); free = Q_DEPTH - count.
- Reset (async assert, sync release): head = tail = 0 → count=0, queue_empty=1, queue_full=0, queue_sat=0, rdata_valid=0, enq_accept=0. mem is not reset; rdata_out contents are undefined while the corresponding rdata_valid bit is 0.
- Enqueue:
  - n_enq = popcount(enqueue_req).
  - enq_accept = (n_enq != 0) && (n_enq <= free), with free taken from registered state before this cycle's dequeue.
  - If accepted, the k-th set lane (ascending lane index) writes mem[(tail+k) mod Q_DEPTH]; tail += n_enq.
  - If not accepted, nothing is written and tail is unchanged. No partial acceptance; the producer holds and retries.
- Dequeue:
  - n_deq = min(deq_num, count).
  - head += n_deq at clk edge.
  - deq_num > DEQ_LANES is clamped to DEQ_LANES.
  - Requesting more than count pops only count; no error, no underflow.
- Read lanes: rdata_out lane i = mem[(head+i) mod Q_DEPTH], combinational from registered head. Valid in the same cycle the caller samples it and pops.
- Latency: an element enqueued at edge E appears on rdata_out/rdata_valid after edge E. No same-cycle bypass.
- Simultaneous enqueue+dequeue:
  - Both apply at one edge: next count = count + (accepted ? n_enq : 0) - n_deq.
  - Acceptance is deliberately conservative: it ignores same-cycle pops.
- Wrap-around:
  - Indices wrap modulo Q_DEPTH; a batch may straddle the end of mem.
  - Full vs empty is distinguished by the polarity bit (count == Q_DEPTH is legal).
- Flags (combinational from registered pointers): queue_full, queue_empty, queue_sat.
- Reset mid-operation: all in-flight elements are discarded immediately; the enq/deq of that cycle are ignored.

Optional Feature:
- Macro: QUEUE_OUT_MLANE_STATS_EN.
- When defined, adds three output ports, all cleared by bfs_rst_n:
  - stat_hiwater (count width): maximum count reached since reset.
  - stat_reject (16 b, saturating): increments each cycle with n_enq != 0 and enq_accept == 0.
  - stat_deq_short (16 b, saturating): increments each cycle with deq_num > count.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold bfs_rst_n=0 with random inputs, release → count=0, queue_empty=1, rdata_valid=00, enq_accept=0. Assert bfs_rst_n mid-stream with count=5 → count=0 asynchronously, before the next edge.
- Compaction: enqueue_req=2'b10 with lane1=0xA, then 2'b11 with {0xC,0xB} → count=3; rdata lanes = 0xA,0xB; pop 2 → lane0=0xC, rdata_valid=01.
- Full/reject: fill to 63 entries, enqueue_req=11 → enq_accept=0, count stays 63; enqueue_req=01 → accepted, count=64, queue_empty=0; enqueue_req=01 with deq_num=1 → rejected, count=63.
- Wrap: advance head/tail to 62 via push/pop pairs, enqueue 4 elements 1..4 → stored at 62,63,0,1; two pops of 2 return 1,2 then 3,4 in order; queue_empty=1 afterwards.
- Over-request/simultaneous: count=1, deq_num=2 plus enqueue 2 → count=2, only the old element popped. With STATS_EN defined, stat_deq_short=1.
- Saturation: count 7→8 sets queue_sat; popping to 7 clears it. With STATS_EN defined, stat_hiwater holds its peak after draining.

Source files
------------

// File: rtl/queue_out_mlane.sv
// queue_out_mlane: element-granular circular FIFO, ENQ_LANES compacting push lanes, DEQ_LANES pop lanes.
// Latency: an element written at edge E is visible on rdata_out/rdata_valid after E; no same-cycle bypass.
// Backpressure: whole batch accepted only if it fits in pre-pop free space, else held; pops clamp to count.
// Optional statistics ports are enabled by defining QUEUE_OUT_MLANE_STATS_EN.
module queue_out_mlane #(
    parameter int DATA_W     = 32,
    parameter int ENQ_LANES  = 2,
    parameter int DEQ_LANES  = 2,
    parameter int Q_DEPTH    = 64,
    parameter int SAT_THRESH = 8
) (
    input  logic                              clk,
    input  logic                              bfs_rst_n,
    input  logic [ENQ_LANES-1:0]              enqueue_req,
    input  logic [ENQ_LANES*DATA_W-1:0]       wdata_in,
    output logic                              enq_accept,
    input  logic [$clog2(DEQ_LANES+1)-1:0]    deq_num,
    output logic [DEQ_LANES*DATA_W-1:0]       rdata_out,
    output logic [DEQ_LANES-1:0]              rdata_valid,
    output logic [$clog2(Q_DEPTH):0]          count,
    output logic                              queue_sat,
    output logic                              queue_full,
    output logic                              queue_empty
`ifdef QUEUE_OUT_MLANE_STATS_EN
    ,
    output logic [$clog2(Q_DEPTH):0]          stat_hiwater,
    output logic [15:0]                       stat_reject,
    output logic [15:0]                       stat_deq_short
`endif
);

    localparam int AW  = $clog2(Q_DEPTH);
    localparam int PW  = AW + 1;
    localparam int DNW = $clog2(DEQ_LANES + 1);
    localparam int CW  = $clog2(ENQ_LANES + 1);

    // Pointers carry one extra polarity bit so full (count == Q_DEPTH) differs from empty.
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [DATA_W-1:0] r_mem [Q_DEPTH];

    logic [PW-1:0]     w_count;
    logic [PW-1:0]     w_free;
    logic [CW-1:0]     w_n_enq;
    logic [AW-1:0]     w_wr_idx [ENQ_LANES];
    logic [AW-1:0]     w_rd_idx [DEQ_LANES];
    logic              w_enq_accept;
    logic [DNW-1:0]    w_deq_clamp;
    logic [PW-1:0]     w_n_deq;
    logic [PW-1:0]     w_tail_nxt;
    logic [PW-1:0]     w_head_nxt;

    assign w_count = r_tail - r_head;
    assign w_free  = PW'(Q_DEPTH) - w_count;

    // Compaction: each requesting lane lands at tail + (number of lower requesting lanes).
    always_comb begin
        logic [CW-1:0] v_sum;
        v_sum = '0;
        for (int i = 0; i < ENQ_LANES; i++) begin
            w_wr_idx[i] = r_tail[AW-1:0] + AW'(v_sum);
            v_sum       = v_sum + CW'(enqueue_req[i]);
        end
        w_n_enq = v_sum;
    end

    // Acceptance looks only at registered free space; same-cycle pops are deliberately ignored.
    assign w_enq_accept = bfs_rst_n && (w_n_enq != '0) && (32'(w_n_enq) <= 32'(w_free));
    assign enq_accept   = w_enq_accept;

    // Pop count: clamp to lane count, then to occupancy, so over-requests never underflow.
    always_comb begin
        w_deq_clamp = (32'(deq_num) > 32'(DEQ_LANES)) ? DNW'(DEQ_LANES) : deq_num;
        w_n_deq     = (32'(w_deq_clamp) > 32'(w_count)) ? w_count : PW'(w_deq_clamp);
    end

    assign w_tail_nxt = r_tail + (w_enq_accept ? PW'(w_n_enq) : '0);
    assign w_head_nxt = r_head + w_n_deq;

    // Pointer update; reset drops everything in flight.
    always_ff @(posedge clk or negedge bfs_rst_n) begin
        if (!bfs_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
        end
    end

    // Storage write for accepted batches; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_LANES; i++) begin
            if (w_enq_accept && enqueue_req[i]) begin
                r_mem[w_wr_idx[i]] <= wdata_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read lanes present the next DEQ_LANES entries from the registered head.
    always_comb begin
        for (int i = 0; i < DEQ_LANES; i++) begin
            w_rd_idx[i]                      = r_head[AW-1:0] + AW'(i);
            rdata_out[i*DATA_W +: DATA_W]    = r_mem[w_rd_idx[i]];
            rdata_valid[i]                   = (32'(w_count) > 32'(i));
        end
    end

    assign count       = w_count;
    assign queue_empty = (w_count == '0);
    assign queue_full  = (32'(w_free) < 32'(ENQ_LANES));
    assign queue_sat   = (32'(w_count) >= 32'(SAT_THRESH));

`ifdef QUEUE_OUT_MLANE_STATS_EN
    logic [PW-1:0] w_count_nxt;
    logic [PW-1:0] r_hiwater;
    logic [15:0]   r_reject;
    logic [15:0]   r_deq_short;

    assign w_count_nxt = w_tail_nxt - w_head_nxt;

    // Peak occupancy plus saturating reject / short-pop event counters.
    always_ff @(posedge clk or negedge bfs_rst_n) begin
        if (!bfs_rst_n) begin
            r_hiwater   <= '0;
            r_reject    <= '0;
            r_deq_short <= '0;
        end else begin
            if (w_count_nxt > r_hiwater) begin
                r_hiwater <= w_count_nxt;
            end
            if ((w_n_enq != '0) && !w_enq_accept && (r_reject != 16'hFFFF)) begin
                r_reject <= r_reject + 16'd1;
            end
            if ((32'(deq_num) > 32'(w_count)) && (r_deq_short != 16'hFFFF)) begin
                r_deq_short <= r_deq_short + 16'd1;
            end
        end
    end

    assign stat_hiwater   = r_hiwater;
    assign stat_reject    = r_reject;
    assign stat_deq_short = r_deq_short;
`endif

endmodule
